// File: rtl/fht_job_sched_pkg.sv
// Shared definitions for the FHT job scheduler: state encodings, bank-mux
// owner codes and the frame-length helper.
package fht_defines;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_START  = 3'd2,
    ST_RUN    = 3'd3,
    ST_UNLOAD = 3'd4,
    ST_DRAIN  = 3'd5
  } fht_state_t;

  localparam logic [1:0] OWNER_LOADER   = 2'd0;
  localparam logic [1:0] OWNER_CORE     = 2'd1;
  localparam logic [1:0] OWNER_UNLOADER = 2'd2;
  localparam logic [1:0] OWNER_NONE     = 2'd3;

  localparam int A_BIT_DEFAULT = 8;

  // Four banks of 2^a_bit words each make up one frame.
  function automatic int frame_len(input int a_bit);
    return 4 << a_bit;
  endfunction

  localparam int N = frame_len(A_BIT_DEFAULT);

endpackage

// File: rtl/fht_job_sched_rd_pipe.sv
// Unloader read pipeline: issues RAM reads under sink backpressure and tracks
// the one-deep output register in the RAM.
module fht_rd_pipe (
  input  logic iCLK,
  input  logic iRESET,
  input  logic unload,
  input  logic drain,
  input  logic iOUT_READY,
  output logic oRD_EN,
  output logic oOUT_VALID,
  output logic oOUT_LAST
);

  logic vld_p1;

  // A read may only be issued when the RAM output register is empty or being consumed.
  assign oRD_EN = unload & (~vld_p1 | iOUT_READY);

  // Stage p1: RAM output register holds valid data
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      vld_p1 <= 1'b0;
    end else if (oRD_EN) begin
      vld_p1 <= 1'b1;
    end else if (iOUT_READY) begin
      vld_p1 <= 1'b0;
    end
  end

  assign oOUT_VALID = vld_p1;
  assign oOUT_LAST  = drain & vld_p1;

endmodule

// File: rtl/fht_job_sched.sv
// Frame scheduler for the FHT core: loads one frame into the banks, starts the
// transform, waits for completion under a watchdog, then streams the result out.
module fht_job_sched
  import fht_defines::*;
#(
  parameter int A_BIT   = 8,
  parameter int TIMEOUT = 4096 * A_BIT
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic             iIN_VALID,
  output logic             oIN_READY,
  output logic             oIN_WE,
  output logic [1:0]       oIN_BANK,
  output logic [A_BIT-1:0] oIN_ADDR,
  output logic             oFHT_START,
  input  logic             iFHT_RDY,
  input  logic             iSOURCE_DATA,
  output logic [1:0]       oOWNER,
  output logic             oRD_EN,
  output logic             oRD_SET,
  output logic [1:0]       oRD_BANK,
  output logic [A_BIT-1:0] oRD_ADDR,
  output logic             oOUT_VALID,
  input  logic             iOUT_READY,
  output logic             oOUT_LAST,
  output logic             oBUSY,
  output logic             oERR,
  input  logic             iCLR_ERR
);

  localparam int FRAME_N = frame_len(A_BIT);
  localparam int IW      = A_BIT + 2;
  localparam int WW      = $clog2(TIMEOUT + 1);

  localparam logic [IW-1:0] N_LAST = IW'(FRAME_N - 1);
  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT);
  localparam logic [WW-1:0] WD_EXP = WW'(TIMEOUT - 1);

  fht_state_t    state;
  logic [IW-1:0] n;
  logic [IW-1:0] m;
  logic [WW-1:0] wdog;
  logic          rdy_d;
  logic          rdy_rise;
  logic          unload;
  logic          drain;

  assign oIN_WE   = iIN_VALID & oIN_READY;
  assign oIN_BANK = n[1:0];
  assign oIN_ADDR = n[IW-1:2];
  assign oRD_BANK = m[1:0];
  assign oRD_ADDR = m[IW-1:2];

  assign unload   = (state == ST_UNLOAD);
  assign drain    = (state == ST_DRAIN);
  // The watchdog is zero only in the first RUN cycle, so this masks rises one cycle after START.
  assign rdy_rise = iFHT_RDY & ~rdy_d & (wdog != '0);

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state      <= ST_IDLE;
      n          <= '0;
      m          <= '0;
      wdog       <= '0;
      rdy_d      <= 1'b0;
      oIN_READY  <= 1'b0;
      oFHT_START <= 1'b0;
      oOWNER     <= OWNER_NONE;
      oBUSY      <= 1'b0;
      oERR       <= 1'b0;
      oRD_SET    <= 1'b0;
    end else begin
      rdy_d <= iFHT_RDY;
      if (iCLR_ERR) oERR <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (iIN_VALID) begin
            state     <= ST_LOAD;
            oIN_READY <= 1'b1;
            oOWNER    <= OWNER_LOADER;
            oBUSY     <= 1'b1;
          end
        end

        ST_LOAD: begin
          if (oIN_WE) begin
            n <= n + 1'b1;
            if (n == N_LAST) begin
              state      <= ST_START;
              oIN_READY  <= 1'b0;
              oFHT_START <= 1'b1;
              oOWNER     <= OWNER_CORE;
            end
          end
        end

        ST_START: begin
          state      <= ST_RUN;
          oFHT_START <= 1'b0;
          wdog       <= '0;
        end

        ST_RUN: begin
          if (rdy_rise) begin
            state   <= ST_UNLOAD;
            oRD_SET <= ~iSOURCE_DATA;
            oOWNER  <= OWNER_UNLOADER;
          end else if (wdog == WD_EXP) begin
            // Timeout set is assigned after the clear above, so it wins.
            state  <= ST_IDLE;
            wdog   <= WD_MAX;
            oERR   <= 1'b1;
            oOWNER <= OWNER_NONE;
            oBUSY  <= 1'b0;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end

        ST_UNLOAD: begin
          if (oRD_EN) begin
            m <= m + 1'b1;
            if (m == N_LAST) state <= ST_DRAIN;
          end
        end

        ST_DRAIN: begin
          if (oOUT_VALID && iOUT_READY) begin
            state  <= ST_IDLE;
            oOWNER <= OWNER_NONE;
            oBUSY  <= 1'b0;
          end
        end

        default: begin
          state      <= ST_IDLE;
          oIN_READY  <= 1'b0;
          oFHT_START <= 1'b0;
          oOWNER     <= OWNER_NONE;
          oBUSY      <= 1'b0;
        end
      endcase
    end
  end

  fht_rd_pipe u_rd_pipe (
    .iCLK       (iCLK),
    .iRESET     (iRESET),
    .unload     (unload),
    .drain      (drain),
    .iOUT_READY (iOUT_READY),
    .oRD_EN     (oRD_EN),
    .oOUT_VALID (oOUT_VALID),
    .oOUT_LAST  (oOUT_LAST)
  );

endmodule

// File: tb/tb_fht_job_sched.sv
// Scoreboard bench for fht_job_sched (A_BIT = 2, TIMEOUT = 50) with a small
// bank RAM model so addressing and output ordering are checked end to end.
module tb_fht_job_sched;

  logic       iCLK = 1'b0;
  logic       iRESET = 1'b0;
  logic       iIN_VALID = 1'b0;
  logic       oIN_READY;
  logic       oIN_WE;
  logic [1:0] oIN_BANK;
  logic [1:0] oIN_ADDR;
  logic       oFHT_START;
  logic       iFHT_RDY = 1'b0;
  logic       iSOURCE_DATA = 1'b0;
  logic [1:0] oOWNER;
  logic       oRD_EN;
  logic       oRD_SET;
  logic [1:0] oRD_BANK;
  logic [1:0] oRD_ADDR;
  logic       oOUT_VALID;
  logic       iOUT_READY = 1'b0;
  logic       oOUT_LAST;
  logic       oBUSY;
  logic       oERR;
  logic       iCLR_ERR = 1'b0;

  fht_job_sched #(.A_BIT(2), .TIMEOUT(50)) dut (
    .iCLK         (iCLK),
    .iRESET       (iRESET),
    .iIN_VALID    (iIN_VALID),
    .oIN_READY    (oIN_READY),
    .oIN_WE       (oIN_WE),
    .oIN_BANK     (oIN_BANK),
    .oIN_ADDR     (oIN_ADDR),
    .oFHT_START   (oFHT_START),
    .iFHT_RDY     (iFHT_RDY),
    .iSOURCE_DATA (iSOURCE_DATA),
    .oOWNER       (oOWNER),
    .oRD_EN       (oRD_EN),
    .oRD_SET      (oRD_SET),
    .oRD_BANK     (oRD_BANK),
    .oRD_ADDR     (oRD_ADDR),
    .oOUT_VALID   (oOUT_VALID),
    .iOUT_READY   (iOUT_READY),
    .oOUT_LAST    (oOUT_LAST),
    .oBUSY        (oBUSY),
    .oERR         (oERR),
    .iCLR_ERR     (iCLR_ERR)
  );

  always #5 iCLK = ~iCLK;

  int n_cmp = 0;
  int n_err = 0;

  logic [4:0] in_q[$];   // {last, bank, addr}
  logic [4:0] out_q[$];  // {last, sample index}
  int         start_chk = 0;

  logic [7:0] sample_val = 8'd0;
  logic [7:0] ram [16];
  logic [7:0] ram_q = 8'd0;

  // Bank RAM with registered read port gated by oRD_EN.
  always @(posedge iCLK) begin
    if (oIN_WE) ram[{oIN_BANK, oIN_ADDR}] <= sample_val;
    if (oRD_EN) ram_q <= ram[{oRD_BANK, oRD_ADDR}];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  function automatic logic [18:0] out_vec();
    return {oIN_READY, oIN_WE, oIN_BANK, oIN_ADDR, oFHT_START, oOWNER, oRD_EN,
            oRD_SET, oRD_BANK, oRD_ADDR, oOUT_VALID, oOUT_LAST, oBUSY, oERR};
  endfunction

  localparam logic [18:0] RESET_VEC = {1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd3, 1'b0,
                                       1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};

  // Sink backpressure pattern 1,0,0,1 repeating.
  initial begin
    logic [3:0] pat;
    pat = 4'b1001;
    for (int k = 0; ; k++) begin
      @(posedge iCLK);
      #1;
      iOUT_READY = pat[k % 4];
    end
  end

  // Monitor: pops expected responses whenever the DUT presents one.
  initial begin
    logic [4:0] e;
    forever begin
      @(negedge iCLK);
      if (start_chk == 1) begin
        check("start_single", oFHT_START, 0);
        start_chk = 0;
      end else if (start_chk == 2) begin
        check("start_pulse", oFHT_START, 1);
        start_chk = 1;
      end else if (oFHT_START) begin
        check("start_spurious", oFHT_START, 0);
      end
      if (oIN_WE) begin
        if (in_q.size() == 0) fail_now("in_extra_handshake");
        else begin
          e = in_q.pop_front();
          check("in_bank", oIN_BANK, e[3:2]);
          check("in_addr", oIN_ADDR, e[1:0]);
          if (e[4]) start_chk = 2;
        end
      end
      if (oOUT_VALID && iOUT_READY) begin
        if (out_q.size() == 0) fail_now("out_extra_sample");
        else begin
          e = out_q.pop_front();
          check("out_data", ram_q, e[3:0]);
          check("out_last", oOUT_LAST, e[4]);
        end
      end
    end
  end

  task automatic send(input int i, input bit push_out);
    logic [3:0] idx;
    bit done;
    idx = 4'(i);
    sample_val = 8'(i);
    in_q.push_back({idx == 4'd15, idx[1:0], idx[3:2]});
    if (push_out) out_q.push_back({idx == 4'd15, idx});
    iIN_VALID = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 8 && !done; c++) begin
      @(negedge iCLK);
      if (oIN_WE) done = 1'b1;
    end
    if (done) begin
      @(posedge iCLK);
      #1;
    end else begin
      fail_now("in_handshake_timeout");
    end
  endtask

  task automatic wait_idle(input string name);
    bit idle;
    idle = 1'b0;
    for (int c = 0; c < 300 && !idle; c++) begin
      @(negedge iCLK);
      if (!oBUSY) idle = 1'b1;
    end
    check(name, idle, 1);
    check("out_queue_drained", out_q.size(), 0);
    @(posedge iCLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values
    repeat (3) @(posedge iCLK);
    #1;
    check("reset_outputs", out_vec(), RESET_VEC);
    iRESET = 1'b1;
    @(posedge iCLK);
    #1;

    // Frame 1: back-to-back load, ready held high through START, rise 20 cycles later
    iFHT_RDY = 1'b1;
    iSOURCE_DATA = 1'b1;
    for (int i = 0; i < 16; i++) send(i, 1'b1);
    iIN_VALID = 1'b0;
    check("start_owner", oOWNER, 1);
    check("start_busy", oBUSY, 1);
    @(posedge iCLK);
    #1;
    iFHT_RDY = 1'b0;
    repeat (19) @(posedge iCLK);
    #1;
    check("run_hold_owner", oOWNER, 1);
    iFHT_RDY = 1'b1;
    @(posedge iCLK);
    #1;
    check("unload_owner", oOWNER, 2);
    check("rd_set_f1", oRD_SET, 0);
    iSOURCE_DATA = 1'b0;
    iFHT_RDY = 1'b0;
    wait_idle("frame1_done");
    check("idle_owner_f1", oOWNER, 3);
    check("rd_set_held_f1", oRD_SET, 0);

    // Frame 2: watchdog expiry with a simultaneous clear
    for (int i = 0; i < 16; i++) send(i, 1'b0);
    iIN_VALID = 1'b0;
    repeat (50) @(posedge iCLK);
    #1;
    check("run_cycle50_owner", oOWNER, 1);
    check("run_cycle50_err", oERR, 0);
    iCLR_ERR = 1'b1;
    @(posedge iCLK);
    #1;
    iCLR_ERR = 1'b0;
    check("timeout_err_set_wins", oERR, 1);
    check("timeout_busy", oBUSY, 0);
    check("timeout_owner", oOWNER, 3);
    check("timeout_no_unload", oOUT_VALID, 0);
    iCLR_ERR = 1'b1;
    @(posedge iCLK);
    #1;
    iCLR_ERR = 1'b0;
    check("err_cleared", oERR, 0);

    // Frame 3: abandoned by reset after 7 samples
    for (int i = 0; i < 7; i++) send(i, 1'b0);
    iIN_VALID = 1'b0;
    iRESET = 1'b0;
    #1;
    check("midframe_reset_outputs", out_vec(), RESET_VEC);
    @(posedge iCLK);
    #1;
    iRESET = 1'b1;
    @(posedge iCLK);
    #1;

    // Frame 4: restarts at bank 0/addr 0; an early rise one cycle after START is ignored
    for (int i = 0; i < 16; i++) send(i, 1'b1);
    iIN_VALID = 1'b0;
    @(posedge iCLK);
    #1;
    iFHT_RDY = 1'b1;
    repeat (2) @(posedge iCLK);
    #1;
    iFHT_RDY = 1'b0;
    repeat (2) @(posedge iCLK);
    #1;
    check("early_rise_ignored", oOWNER, 1);
    iFHT_RDY = 1'b1;
    @(posedge iCLK);
    #1;
    check("unload_owner_f4", oOWNER, 2);
    check("rd_set_f4", oRD_SET, 1);
    iFHT_RDY = 1'b0;
    wait_idle("frame4_done");
    check("in_queue_drained", in_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fht_job_sched.md
FHT_JOB_SCHED -- requirements
Module: fht_job_sched

Interface
REQ-001 Parameter A_BIT, default 8: address width of one bank; frame length N = 4*2^A_BIT points.
REQ-002 Parameter TIMEOUT, default 4096*A_BIT: maximum cycles the RUN state may last.
REQ-003 Port iCLK  in  1: clock; every register is clocked on the rising edge.
REQ-004 Port iRESET  in  1: reset, asynchronous, active-low.
REQ-005 Port iIN_VALID  in  1: the input sample is valid this cycle.
REQ-006 Port oIN_READY  out  1: the scheduler accepts an input sample.
REQ-007 Port oIN_WE  out  1: bank write strobe for the loader path (iIN_VALID & oIN_READY).
REQ-008 Port oIN_BANK  out  2: target bank for the accepted sample.
REQ-009 Port oIN_ADDR  out  A_BIT: target address for the accepted sample.
REQ-010 Port oFHT_START  out  1: one-cycle start pulse to the FHT controller.
REQ-011 Port iFHT_RDY  in  1: FHT controller ready/done level.
REQ-012 Port iSOURCE_DATA  in  1: FHT bank-set select; sampled at completion.
REQ-013 Port oOWNER  out  2: bank mux owner; 0 = loader, 1 = core, 2 = unloader, 3 = none.
REQ-014 Port oRD_EN  out  1: read enable and output-register enable for the unloader read.
REQ-015 Port oRD_SET  out  1: bank set to read, latched from iSOURCE_DATA.
REQ-016 Port oRD_BANK  out  2: bank to read.
REQ-017 Port oRD_ADDR  out  A_BIT: address to read.
REQ-018 Port oOUT_VALID  out  1: RAM read data is valid on the external output.
REQ-019 Port iOUT_READY  in  1: the downstream sink accepts the output sample.
REQ-020 Port oOUT_LAST  out  1: marks the final sample of a frame.
REQ-021 Port oBUSY  out  1: high whenever the state is not IDLE.
REQ-022 Port oERR  out  1: sticky timeout flag.
REQ-023 Port iCLR_ERR  in  1: clears oERR.

Function
REQ-024 The state machine SHALL have the states IDLE, LOAD, START, RUN, UNLOAD and DRAIN.
REQ-025 IDLE -> LOAD on iIN_VALID; oOWNER = 3.
REQ-026 In LOAD: oIN_READY = 1 and oOWNER = 0; the sample index n (A_BIT+2 bits) increments on each handshake.
REQ-027 In LOAD, the sample address SHALL be oIN_BANK = n[1:0] and oIN_ADDR = n[A_BIT+1:2].
REQ-028 LOAD -> START SHALL occur on the handshake at n = N-1; n then wraps to 0.
REQ-029 START SHALL last exactly 1 cycle: oFHT_START = 1 and oOWNER = 1; START -> RUN.
REQ-030 In RUN: oOWNER = 1; the watchdog counts cycles.
REQ-031 RUN completes on the first rising edge of iFHT_RDY that occurs at least 2 cycles after START; earlier levels are ignored.
REQ-032 On RUN completion, the scheduler SHALL latch oRD_SET = ~iSOURCE_DATA and move to UNLOAD.
REQ-033 On watchdog expiry in RUN: set oERR and return to IDLE; no unload takes place.
REQ-034 In UNLOAD: oOWNER = 2; oRD_EN = !oOUT_VALID | iOUT_READY.
REQ-035 In UNLOAD, the read index m SHALL advance on each oRD_EN, with oRD_BANK = m[1:0] and oRD_ADDR = m[A_BIT+1:2].
REQ-036 oOUT_VALID SHALL be oRD_EN delayed by 1 cycle; it holds while iOUT_READY = 0, and the RAM output register also holds because oRD_EN = 0.
REQ-037 UNLOAD -> DRAIN after the read of m = N-1 is issued.
REQ-038 In DRAIN: oRD_EN = 0 and oOUT_LAST = oOUT_VALID.
REQ-039 DRAIN -> IDLE on the final output handshake.
REQ-040 When oOUT_VALID = 1 and iOUT_READY = 1 with a new read issued in the same cycle, oOUT_VALID SHALL stay 1 (back-to-back throughput of 1 sample per cycle).
REQ-041 iIN_VALID SHALL be ignored outside IDLE and LOAD; oIN_READY = 0 in all other states.
REQ-042 iCLR_ERR clears oERR; if iCLR_ERR coincides with a timeout in the same cycle, the set wins.
REQ-043 Counters n and m SHALL wrap modulo N; the watchdog counter SHALL saturate at TIMEOUT.

Reset
REQ-044 On iRESET low: state = IDLE; n = m = 0; watchdog = 0.
REQ-045 On iRESET low, all outputs SHALL be 0 except oOWNER = 3.
REQ-046 Reset asserted mid-frame SHALL abandon the frame; the first frame after reset starts again at n = 0.

Structure
REQ-047 The shared package fht_defines SHALL hold the state encodings, the OWNER_* codes, and the derived constant N.
REQ-048 The unloader read pipeline (oRD_EN, oOUT_VALID, oOUT_LAST) SHALL be one sub-module, fht_rd_pipe; the rest SHALL stay flat.

Verification
REQ-049 A_BIT = 2, 16 samples streamed back-to-back -> oIN_BANK/oIN_ADDR follow (0,0),(1,0),(2,0),(3,0),(0,1)..., and one oFHT_START pulse occurs on the cycle after the 16th handshake.
REQ-050 iFHT_RDY held high during START and rising 20 cycles later -> UNLOAD entered on that rise only; with iSOURCE_DATA = 1, oRD_SET = 0.
REQ-051 iOUT_READY toggling 1,0,0,1 -> no sample is lost or duplicated; the 16 outputs appear in order 0..15 and oOUT_LAST = 1 on the 16th only.
REQ-052 TIMEOUT = 50 with iFHT_RDY stuck low -> oERR = 1 at cycle 50 of RUN, then IDLE; a simultaneous iCLR_ERR pulse leaves oERR = 1.
REQ-053 iRESET asserted after 7 loaded samples -> all outputs return to reset values; the next frame starts at bank 0, addr 0.
